// File: rtl/http_run_sequencer_if.sv
// Configuration beat channel and engine control/status signals between
// the HTTP run sequencer (master) and the network stack / engine (slave).
interface http_run_sequencer_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_sel;
    logic [31:0] cfg_data;
    logic        eng_run;
    logic        eng_req_done;
    logic        eng_finish;
    logic        eng_busy;

    modport master (
        output cfg_valid, cfg_sel, cfg_data, eng_run,
        input  cfg_ready, eng_req_done, eng_finish, eng_busy
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_data, eng_run,
        output cfg_ready, eng_req_done, eng_finish, eng_busy
    );
endinterface

// File: rtl/http_run_sequencer.sv
// Kernel-side execution sequencer for the HTTP kernel.
// Accepts ap_start from the control block, pushes ip/board/arp to the network
// stack as three config beats, runs the engine until it finishes or the RUN
// phase times out, waits for outstanding requests to drain, then pulses
// ap_done. Every output comes from a register or from decoded state.
module http_run_sequencer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd0,
    parameter int          CNT_W          = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 ACLK_EN,
    input  logic                 ap_start,
    output logic                 ap_ready,
    output logic                 ap_idle,
    output logic                 ap_done,
    input  logic [31:0]          ip_addr,
    input  logic [31:0]          board_number,
    input  logic [31:0]          arp,
    http_run_sequencer_if.master bus,
    output logic [CNT_W-1:0]     req_served,
    output logic                 timed_out
);

    typedef enum logic [2:0] {
        IDLE,
        CFG_IP,
        CFG_BOARD,
        CFG_ARP,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state;
    state_t      state_next;
    logic [31:0] ip_q;
    logic [31:0] board_q;
    logic [31:0] arp_q;
    logic [31:0] tmo_cnt;
    logic        ap_ready_q;
    logic        accept;
    logic        timeout_exit;
    logic        tmo_hit;

    // The timeout fires on the last allowed RUN cycle; a zero length disables it.
    assign tmo_hit = (TIMEOUT_CYCLES != 32'd0) && (tmo_cnt == (TIMEOUT_CYCLES - 32'd1));

    // Next-state decision; a finishing engine takes priority over the timeout.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        timeout_exit = 1'b0;
        case (state)
            IDLE: begin
                if (ap_start) begin
                    state_next = CFG_IP;
                    accept     = 1'b1;
                end
            end
            CFG_IP:    if (bus.cfg_ready) state_next = CFG_BOARD;
            CFG_BOARD: if (bus.cfg_ready) state_next = CFG_ARP;
            CFG_ARP:   if (bus.cfg_ready) state_next = RUN;
            RUN: begin
                if (bus.eng_finish) begin
                    state_next = DRAIN;
                end else if (tmo_hit) begin
                    state_next   = DRAIN;
                    timeout_exit = 1'b1;
                end
            end
            DRAIN:   if (!bus.eng_busy) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, frozen while the clock enable is low.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else if (ACLK_EN) begin
            state <= state_next;
        end
    end

    // Argument latch, ap_ready pulse, timeout counter and served-request bookkeeping.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ip_q       <= 32'd0;
            board_q    <= 32'd0;
            arp_q      <= 32'd0;
            tmo_cnt    <= 32'd0;
            ap_ready_q <= 1'b0;
            req_served <= '0;
            timed_out  <= 1'b0;
        end else if (ACLK_EN) begin
            ap_ready_q <= accept;
            if (accept) begin
                ip_q       <= ip_addr;
                board_q    <= board_number;
                arp_q      <= arp;
                tmo_cnt    <= 32'd0;
                req_served <= '0;
                timed_out  <= 1'b0;
            end else begin
                if (state == RUN) begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                end
                if (timeout_exit) begin
                    timed_out <= 1'b1;
                end
                if (((state == RUN) || (state == DRAIN)) && bus.eng_req_done && (req_served != CNT_MAX)) begin
                    req_served <= req_served + CNT_ONE;
                end
            end
        end
    end

    // Output decode from the registered state and latched arguments.
    always_comb begin
        ap_idle      = 1'b0;
        ap_done      = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_sel   = 2'd0;
        bus.cfg_data  = 32'd0;
        bus.eng_run   = 1'b0;
        case (state)
            IDLE: ap_idle = 1'b1;
            CFG_IP: begin
                bus.cfg_valid = 1'b1;
                bus.cfg_sel   = 2'd0;
                bus.cfg_data  = ip_q;
            end
            CFG_BOARD: begin
                bus.cfg_valid = 1'b1;
                bus.cfg_sel   = 2'd1;
                bus.cfg_data  = board_q;
            end
            CFG_ARP: begin
                bus.cfg_valid = 1'b1;
                bus.cfg_sel   = 2'd2;
                bus.cfg_data  = arp_q;
            end
            RUN:     bus.eng_run = 1'b1;
            DONE:    ap_done = 1'b1;
            default: ;
        endcase
    end

    assign ap_ready = ap_ready_q;

endmodule

// File: tb/tb_http_run_sequencer.sv
// Self-checking bench for http_run_sequencer: a job-level model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_http_run_sequencer;

    localparam logic [31:0] TMO   = 32'd20;
    localparam int          CNT_W = 32;
    localparam logic [CNT_W-1:0] SAT = '1;

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic             ACLK_EN;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_idle;
    logic             ap_done;
    logic [31:0]      ip_addr;
    logic [31:0]      board_number;
    logic [31:0]      arp;
    logic [CNT_W-1:0] req_served;
    logic             timed_out;

    http_run_sequencer_if bus();

    http_run_sequencer #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (CNT_W)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .ACLK_EN     (ACLK_EN),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .ip_addr     (ip_addr),
        .board_number(board_number),
        .arp         (arp),
        .bus         (bus),
        .req_served  (req_served),
        .timed_out   (timed_out)
    );

    always #5 ACLK = ~ACLK;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Job-level reference model: which phase of the job we are in, which
    // config beat is pending, how many RUN cycles have elapsed.
    typedef enum int {M_IDLE, M_CFG, M_RUN, M_DRAIN, M_DONE} mphase_t;
    mphase_t          m_phase      = M_IDLE;
    int               m_beat       = 0;
    int               m_run_cycles = 0;
    logic [31:0]      m_args [3];
    logic             m_ready      = 1'b0;
    logic             m_tmo        = 1'b0;
    logic [CNT_W-1:0] m_served     = '0;

    // Monitors for the directed literal checks.
    int          cyc       = 0;
    int          mon_ready = 0;
    int          mon_done  = 0;
    int          mon_run   = 0;
    int          mon_idle  = 0;
    int          mon_sel1  = 0;
    logic [33:0] beats [$];
    int          beat_cyc [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic applyStimulus(input logic rdy, input logic req, input logic fin, input logic busy);
        bus.cfg_ready    = rdy;
        bus.eng_req_done = req;
        bus.eng_finish   = fin;
        bus.eng_busy     = busy;
        tick();
    endtask

    task automatic clearMonitors();
        mon_ready = 0;
        mon_done  = 0;
        mon_run   = 0;
        mon_idle  = 0;
        mon_sel1  = 0;
        beats.delete();
        beat_cyc.delete();
    endtask

    // which: 0 = eng_run, 1 = ap_done, 2 = ap_idle
    task automatic waitFor(input string what, input int which, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            seen = (which == 0) ? bus.eng_run : (which == 1) ? ap_done : ap_idle;
            if (!seen) tick();
        end
        if (!seen) begin
            n_vectors++;
            n_miscompares++;
            $display("[TB] FAIL wait_%s: got no event in %0d cycles, expected event", what, budget);
        end
    endtask

    task automatic startJob(input logic [31:0] ip, input logic [31:0] board, input logic [31:0] a);
        bit got;
        got          = 1'b0;
        ip_addr      = ip;
        board_number = board;
        arp          = a;
        ap_start     = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = ap_ready;
        end
        ap_start = 1'b0;
        if (!got) begin
            n_vectors++;
            n_miscompares++;
            $display("[TB] FAIL start_accept: got no ap_ready, expected ap_ready within 20 cycles");
        end
    endtask

    // Model update on each active edge, from the inputs the DUT sees.
    initial forever begin
        @(posedge ACLK);
        if (ARESET) begin
            m_phase      = M_IDLE;
            m_beat       = 0;
            m_run_cycles = 0;
            m_ready      = 1'b0;
            m_tmo        = 1'b0;
            m_served     = '0;
        end else if (ACLK_EN) begin
            m_ready = 1'b0;
            if ((m_phase == M_RUN || m_phase == M_DRAIN) && bus.eng_req_done && m_served != SAT)
                m_served = m_served + CNT_W'(1);
            case (m_phase)
                M_IDLE: begin
                    if (ap_start) begin
                        m_args[0]    = ip_addr;
                        m_args[1]    = board_number;
                        m_args[2]    = arp;
                        m_served     = '0;
                        m_tmo        = 1'b0;
                        m_run_cycles = 0;
                        m_beat       = 0;
                        m_ready      = 1'b1;
                        m_phase      = M_CFG;
                    end
                end
                M_CFG: begin
                    if (bus.cfg_ready) begin
                        if (m_beat == 2) m_phase = M_RUN;
                        else             m_beat  = m_beat + 1;
                    end
                end
                M_RUN: begin
                    m_run_cycles = m_run_cycles + 1;
                    if (bus.eng_finish) begin
                        m_phase = M_DRAIN;
                    end else if (TMO != 32'd0 && m_run_cycles == int'(TMO)) begin
                        m_phase = M_DRAIN;
                        m_tmo   = 1'b1;
                    end
                end
                M_DRAIN: if (!bus.eng_busy) m_phase = M_DONE;
                default: m_phase = M_IDLE;
            endcase
        end
    end

    // Compare every output against the model in the middle of each cycle.
    initial forever begin
        @(negedge ACLK);
        checkOutput("ap_ready",   ap_ready,      m_ready);
        checkOutput("ap_idle",    ap_idle,       m_phase == M_IDLE);
        checkOutput("ap_done",    ap_done,       m_phase == M_DONE);
        checkOutput("cfg_valid",  bus.cfg_valid, m_phase == M_CFG);
        checkOutput("cfg_sel",    bus.cfg_sel,   (m_phase == M_CFG) ? 32'(m_beat) : 32'd0);
        checkOutput("cfg_data",   bus.cfg_data,  (m_phase == M_CFG) ? m_args[m_beat] : 32'd0);
        checkOutput("eng_run",    bus.eng_run,   m_phase == M_RUN);
        checkOutput("req_served", req_served,    m_served);
        checkOutput("timed_out",  timed_out,     m_tmo);
        cyc++;
        if (ap_ready)    mon_ready++;
        if (ap_done)     mon_done++;
        if (bus.eng_run) mon_run++;
        if (ap_idle)     mon_idle++;
        if (bus.cfg_valid && bus.cfg_sel == 2'd1 && bus.cfg_data == 32'd3) mon_sel1++;
        if (bus.cfg_valid && bus.cfg_ready && ACLK_EN) begin
            beats.push_back({bus.cfg_sel, bus.cfg_data});
            beat_cyc.push_back(cyc);
        end
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        logic [1:0]  exp_sel [3];
        logic [31:0] exp_dat [3];

        ARESET           = 1'b1;
        ACLK_EN          = 1'b1;
        ap_start         = 1'b0;
        ip_addr          = 32'd0;
        board_number     = 32'd0;
        arp              = 32'd0;
        bus.cfg_ready    = 1'b0;
        bus.eng_req_done = 1'b0;
        bus.eng_finish   = 1'b0;
        bus.eng_busy     = 1'b0;
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("rst_idle",   ap_idle,       1);
        checkOutput("rst_ready",  ap_ready,      0);
        checkOutput("rst_done",   ap_done,       0);
        checkOutput("rst_valid",  bus.cfg_valid, 0);
        checkOutput("rst_sel",    bus.cfg_sel,   0);
        checkOutput("rst_data",   bus.cfg_data,  0);
        checkOutput("rst_run",    bus.eng_run,   0);
        checkOutput("rst_served", req_served,    0);
        checkOutput("rst_tmo",    timed_out,     0);
        ARESET = 1'b0;
        tick();

        $display("[TB] basic job");
        clearMonitors();
        bus.cfg_ready = 1'b1;
        bus.eng_busy  = 1'b0;
        startJob(32'h0A00_0001, 32'd3, 32'h55);
        waitFor("run1", 0, 10);
        repeat (9) tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        bus.eng_finish = 1'b0;
        waitFor("done1", 1, 10);
        repeat (2) tick();
        exp_sel = '{2'd0, 2'd1, 2'd2};
        exp_dat = '{32'h0A00_0001, 32'd3, 32'h55};
        checkOutput("basic_beats", beats.size(), 3);
        if (beats.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("basic_beat_sel",  beats[i][33:32], exp_sel[i]);
                checkOutput("basic_beat_data", beats[i][31:0],  exp_dat[i]);
            end
            checkOutput("basic_beat_gap01", beat_cyc[1] - beat_cyc[0], 1);
            checkOutput("basic_beat_gap12", beat_cyc[2] - beat_cyc[1], 1);
        end
        checkOutput("basic_ready_pulses", mon_ready, 1);
        checkOutput("basic_run_cycles",   mon_run,   10);
        checkOutput("basic_done_pulses",  mon_done,  1);
        checkOutput("basic_timed_out",    timed_out, 0);
        checkOutput("basic_served",       req_served, 0);

        $display("[TB] config backpressure");
        clearMonitors();
        startJob(32'hC0A8_0101, 32'd3, 32'hAA);
        tick();
        bus.cfg_ready = 1'b0;
        repeat (4) tick();
        bus.cfg_ready = 1'b1;
        waitFor("run2", 0, 10);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        bus.eng_finish = 1'b0;
        waitFor("done2", 1, 10);
        tick();
        exp_dat = '{32'hC0A8_0101, 32'd3, 32'hAA};
        checkOutput("bp_board_cycles", mon_sel1, 5);
        checkOutput("bp_beats", beats.size(), 3);
        if (beats.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("bp_beat_sel",  beats[i][33:32], exp_sel[i]);
                checkOutput("bp_beat_data", beats[i][31:0],  exp_dat[i]);
            end
        end
        checkOutput("bp_run_cycles", mon_run, 1);

        $display("[TB] timeout");
        clearMonitors();
        startJob(32'd1, 32'd2, 32'd3);
        waitFor("run3", 0, 10);
        waitFor("done3", 1, 40);
        tick();
        checkOutput("tmo_run_cycles", mon_run,   20);
        checkOutput("tmo_flag",       timed_out, 1);
        clearMonitors();
        startJob(32'd4, 32'd5, 32'd6);
        checkOutput("tmo_clear_on_accept", timed_out, 0);
        waitFor("run4", 0, 10);
        repeat (19) tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        bus.eng_finish = 1'b0;
        waitFor("done4", 1, 10);
        tick();
        checkOutput("tie_run_cycles", mon_run,   20);
        checkOutput("tie_flag",       timed_out, 0);

        $display("[TB] drain and count");
        clearMonitors();
        startJob(32'h11, 32'h22, 32'h33);
        waitFor("run5", 0, 10);
        for (int c = 1; c <= 12; c++)
            applyStimulus(1'b1, (c % 2 == 1) || (c == 12), c == 12, c == 12);
        for (int i = 1; i <= 6; i++)
            applyStimulus(1'b1, (i == 2) || (i == 5), 1'b0, 1'b1);
        checkOutput("drain_no_early_done", ap_done, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("drain_done_at7",  ap_done,    1);
        checkOutput("drain_served",    req_served, 9);
        checkOutput("drain_run_cycles", mon_run,   12);
        tick();
        checkOutput("drain_served_hold", req_served, 9);

        $display("[TB] back-to-back restart");
        waitFor("idle6", 2, 10);
        clearMonitors();
        ap_start       = 1'b1;
        bus.eng_finish = 1'b1;
        repeat (21) tick();
        ap_start       = 1'b0;
        bus.eng_finish = 1'b0;
        checkOutput("b2b_idle_cycles",  mon_idle,  3);
        checkOutput("b2b_ready_pulses", mon_ready, 3);
        checkOutput("b2b_done_pulses",  mon_done,  3);
        checkOutput("b2b_run_cycles",   mon_run,   3);
        repeat (2) tick();

        $display("[TB] reset mid-run");
        clearMonitors();
        startJob(32'h77, 32'h88, 32'h99);
        waitFor("run7", 0, 10);
        repeat (3) tick();
        ARESET = 1'b1;
        tick();
        checkOutput("mrst_run",   bus.eng_run, 0);
        checkOutput("mrst_idle",  ap_idle,     1);
        checkOutput("mrst_done",  ap_done,     0);
        ARESET = 1'b0;
        repeat (5) tick();
        checkOutput("mrst_no_done", mon_done, 0);
        checkOutput("mrst_still_idle", ap_idle, 1);

        $display("[TB] clock enable");
        clearMonitors();
        startJob(32'hAB, 32'hCD, 32'hEF);
        ACLK_EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("en_hold_sel",   bus.cfg_sel,   0);
            checkOutput("en_hold_valid", bus.cfg_valid, 1);
            checkOutput("en_hold_ready", ap_ready,      1);
        end
        ACLK_EN = 1'b1;
        tick();
        checkOutput("en_resume_sel",  bus.cfg_sel, 1);
        checkOutput("en_ready_drop",  ap_ready,    0);
        waitFor("run8", 0, 10);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        bus.eng_finish = 1'b0;
        waitFor("done8", 1, 10);
        tick();
        checkOutput("en_beats", beats.size(), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
